// File: rtl/mw_wb_stage_if.sv
// mw_wb_stage_if: M-to-W pipeline bus for the writeback stage.
// Signals:
//   m_valid, m_pc, m_reg_we, m_reg_addr, m_wb_sel, m_alu_result, m_mem_rdata,
//   m_load_type : M-stage instruction fields entering W.
//   stall, flush : hazard controls (hold W / load a bubble into W).
//   w_pc, w_we, w_addr, w_data, w_valid : W-stage outputs to the GRF.
//   retire_cnt   : running count of retired instructions.
// Modports: slave = the stage itself, master = whoever drives the M side.
interface mw_wb_stage_if;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_reg_we;
    logic [4:0]  m_reg_addr;
    logic [1:0]  m_wb_sel;
    logic [31:0] m_alu_result;
    logic [31:0] m_mem_rdata;
    logic [2:0]  m_load_type;
    logic        stall;
    logic        flush;
    logic [31:0] w_pc;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        w_valid;
    logic [31:0] retire_cnt;

    modport slave (
        input  m_valid, m_pc, m_reg_we, m_reg_addr, m_wb_sel, m_alu_result,
               m_mem_rdata, m_load_type, stall, flush,
        output w_pc, w_we, w_addr, w_data, w_valid, retire_cnt
    );

    modport master (
        output m_valid, m_pc, m_reg_we, m_reg_addr, m_wb_sel, m_alu_result,
               m_mem_rdata, m_load_type, stall, flush,
        input  w_pc, w_we, w_addr, w_data, w_valid, retire_cnt
    );
endinterface

// File: rtl/mw_wb_stage.sv
// mw_wb_stage: M/W pipeline register with writeback data select, load
// extraction and a retired-instruction counter.
// Ports:
//   clk   : sole clock, all state updates on posedge.
//   reset : synchronous active-low reset.
//   bus   : mw_wb_stage_if.slave (M-stage inputs, stall/flush, W outputs).
// Configuration:
//   MW_SUBWORD_LOAD_EN defined   -> lb/lbu/lh/lhu extraction from the data word.
//   MW_SUBWORD_LOAD_EN undefined -> memory source always returns the raw word.
// All outputs come from registers (plus logic on registers only), so there is
// no combinational path from stall/flush to any output.
module mw_wb_stage (
    input logic          clk,
    input logic          reset,
    mw_wb_stage_if.slave bus
);
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] retire_q, retire_d;
    logic [31:0] mem_data;
`ifdef MW_SUBWORD_LOAD_EN
    logic [2:0]  lt_q, lt_d;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
`endif

    // Flush wins over stall; a bubble zeroes every field.
    always_comb begin
        valid_d  = bus.flush ? 1'b0  : bus.stall ? valid_q : bus.m_valid;
        pc_d     = bus.flush ? 32'd0 : bus.stall ? pc_q    : bus.m_pc;
        we_d     = bus.flush ? 1'b0  : bus.stall ? we_q    : bus.m_reg_we;
        addr_d   = bus.flush ? 5'd0  : bus.stall ? addr_q  : bus.m_reg_addr;
        sel_d    = bus.flush ? 2'd0  : bus.stall ? sel_q   : bus.m_wb_sel;
        alu_d    = bus.flush ? 32'd0 : bus.stall ? alu_q   : bus.m_alu_result;
        rdata_d  = bus.flush ? 32'd0 : bus.stall ? rdata_q : bus.m_mem_rdata;
        // The instruction leaving W retires whenever W is not held.
        retire_d = (!bus.stall && valid_q) ? retire_q + 32'd1 : retire_q;
`ifdef MW_SUBWORD_LOAD_EN
        lt_d     = bus.flush ? 3'd0  : bus.stall ? lt_q    : bus.m_load_type;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            pc_q     <= 32'd0;
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            sel_q    <= 2'd0;
            alu_q    <= 32'd0;
            rdata_q  <= 32'd0;
            retire_q <= 32'd0;
`ifdef MW_SUBWORD_LOAD_EN
            lt_q     <= 3'd0;
`endif
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            alu_q    <= alu_d;
            rdata_q  <= rdata_d;
            retire_q <= retire_d;
`ifdef MW_SUBWORD_LOAD_EN
            lt_q     <= lt_d;
`endif
        end
    end

`ifdef MW_SUBWORD_LOAD_EN
    // Halfword lane ignores alu[0]; unknown load types behave as lw.
    always_comb begin
        byte_v   = rdata_q[{alu_q[1:0], 3'b000} +: 8];
        half_v   = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        mem_data = lt_q == 3'd1 ? {{24{byte_v[7]}}, byte_v} :
                   lt_q == 3'd2 ? {24'd0, byte_v} :
                   lt_q == 3'd3 ? {{16{half_v[15]}}, half_v} :
                   lt_q == 3'd4 ? {16'd0, half_v} : rdata_q;
    end
`else
    assign mem_data = rdata_q;
`endif

    // wb_sel 11 is reserved and falls back to the ALU result.
    assign bus.w_data     = sel_q == 2'b01 ? mem_data :
                            sel_q == 2'b10 ? pc_q + 32'd8 : alu_q;
    assign bus.w_we       = valid_q & we_q & (addr_q != 5'd0);
    assign bus.w_addr     = addr_q;
    assign bus.w_pc       = pc_q;
    assign bus.w_valid    = valid_q;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_mw_wb_stage.sv
// tb_mw_wb_stage: randomized + directed bench for mw_wb_stage against a
// slot-level behavioural model.
module tb_mw_wb_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    mw_wb_stage_if bus();
    mw_wb_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  a;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [2:0]  lt;
    } slot_t;

    slot_t       ms = '0;
    logic [31:0] mcnt = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input slot_t s);
`ifdef MW_SUBWORD_LOAD_EN
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(s.rd >> (8 * s.alu[1:0]));
        h = 16'(s.rd >> (16 * s.alu[1]));
`endif
        if (s.sel == 2'd2) return s.pc + 32'd8;
        if (s.sel != 2'd1) return s.alu;
`ifdef MW_SUBWORD_LOAD_EN
        if (s.lt == 3'd1) return 32'($signed(b));
        if (s.lt == 3'd2) return 32'(b);
        if (s.lt == 3'd3) return 32'($signed(h));
        if (s.lt == 3'd4) return 32'(h);
`endif
        return s.rd;
    endfunction

    // Model update on each edge, then compare every output shortly after.
    always @(posedge clk) begin
        if (!reset) begin
            ms   = '0;
            mcnt = 32'd0;
        end else begin
            if (!bus.stall && ms.v) mcnt = mcnt + 32'd1;
            if (bus.flush) ms = '0;
            else if (!bus.stall)
                ms = '{bus.m_valid, bus.m_pc, bus.m_reg_we, bus.m_reg_addr, bus.m_wb_sel,
                       bus.m_alu_result, bus.m_mem_rdata, bus.m_load_type};
        end
        #1;
        chk("w_valid", 32'(bus.w_valid), 32'(ms.v));
        chk("w_we", 32'(bus.w_we), 32'(ms.v && ms.we && ms.a != 5'd0));
        chk("w_addr", 32'(bus.w_addr), 32'(ms.a));
        chk("w_pc", bus.w_pc, ms.pc);
        chk("w_data", bus.w_data, exp_data(ms));
        chk("retire_cnt", bus.retire_cnt, mcnt);
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] a,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [2:0] lt, input logic st, input logic fl);
        @(negedge clk);
        bus.m_valid = v;
        bus.m_pc = pc;
        bus.m_reg_we = we;
        bus.m_reg_addr = a;
        bus.m_wb_sel = sel;
        bus.m_alu_result = alu;
        bus.m_mem_rdata = rd;
        bus.m_load_type = lt;
        bus.stall = st;
        bus.flush = fl;
    endtask

    task automatic cycle(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] a,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [2:0] lt, input logic st, input logic fl);
        drive(v, pc, we, a, sel, alu, rd, lt, st, fl);
        @(posedge clk);
        #2;
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        logic [31:0] held;
        logic        sub;
`ifdef MW_SUBWORD_LOAD_EN
        sub = 1'b1;
`else
        sub = 1'b0;
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("rst w_valid", 32'(bus.w_valid), 32'd0);
        chk("rst w_we", 32'(bus.w_we), 32'd0);
        chk("rst w_addr", 32'(bus.w_addr), 32'd0);
        chk("rst w_pc", bus.w_pc, 32'd0);
        chk("rst w_data", bus.w_data, 32'd0);
        chk("rst retire", bus.retire_cnt, 32'd0);

        cycle(1, 32'h100, 1, 5, 2'b00, 32'h1234, 0, 0, 0, 0);
        chk("alu we", 32'(bus.w_we), 32'd1);
        chk("alu addr", 32'(bus.w_addr), 32'd5);
        chk("alu data", bus.w_data, 32'h00001234);
        cycle(1, 32'h104, 1, 0, 2'b00, 32'h1234, 0, 0, 0, 0);
        chk("x0 we", 32'(bus.w_we), 32'd0);
        chk("retire after 1", bus.retire_cnt, 32'd1);

        cycle(1, 32'h108, 1, 3, 2'b01, 32'h1003, RD, 3'd1, 0, 0);
        chk("lb", bus.w_data, sub ? 32'hFFFFFF80 : RD);
        cycle(1, 32'h10C, 1, 3, 2'b01, 32'h1003, RD, 3'd2, 0, 0);
        chk("lbu", bus.w_data, sub ? 32'h00000080 : RD);
        cycle(1, 32'h110, 1, 3, 2'b01, 32'h1001, RD, 3'd3, 0, 0);
        chk("lh", bus.w_data, sub ? 32'h00007F01 : RD);
        cycle(1, 32'h114, 1, 3, 2'b01, 32'h1003, RD, 3'd4, 0, 0);
        chk("lhu", bus.w_data, sub ? 32'h000080FF : RD);
        cycle(1, 32'h118, 1, 3, 2'b01, 32'h1002, RD, 3'd0, 0, 0);
        chk("lw", bus.w_data, RD);

        cycle(1, 32'h00003000, 1, 31, 2'b10, 32'hDEAD, 0, 0, 0, 0);
        chk("pc8", bus.w_data, 32'h00003008);
        cycle(1, 32'hFFFFFFFC, 1, 31, 2'b10, 32'hDEAD, 0, 0, 0, 0);
        chk("pc8 wrap", bus.w_data, 32'h00000004);
        cycle(1, 32'h120, 1, 4, 2'b11, 32'h5555, RD, 0, 0, 0);
        chk("sel11", bus.w_data, 32'h00005555);

        cycle(1, 32'h2000, 1, 7, 2'b00, 32'hAAAA, 0, 0, 0, 0);
        held = mcnt;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h3000 + 32'(i), 1, 9, 2'b10, 32'h77, 1, 1, 1, 0);
            chk("stall data", bus.w_data, 32'h0000AAAA);
            chk("stall pc", bus.w_pc, 32'h2000);
            chk("stall addr", 32'(bus.w_addr), 32'd7);
            chk("stall retire", bus.retire_cnt, held);
        end
        cycle(1, 32'h4000, 1, 9, 2'b00, 32'h99, 0, 0, 1, 1);
        chk("flush valid", 32'(bus.w_valid), 32'd0);
        chk("flush pc", bus.w_pc, 32'd0);
        chk("flush we", 32'(bus.w_we), 32'd0);
        chk("flush retire", bus.retire_cnt, held);

        cycle(1, 32'h5000, 1, 2, 2'b00, 32'h1, 0, 0, 0, 0);
        @(negedge clk);
        dut.retire_q = 32'hFFFFFFFF;
        mcnt = 32'hFFFFFFFF;
        @(posedge clk);
        #2;
        chk("retire wrap", bus.retire_cnt, 32'd0);

        cycle(1, 32'h6000, 1, 2, 2'b00, 32'h1, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("midrst retire", bus.retire_cnt, 32'd0);
        chk("midrst valid", 32'(bus.w_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        repeat (600) begin
            logic v;
            v = 1'($urandom);
            drive(v, v ? $urandom : 32'd0, 1'($urandom), 5'($urandom), 2'($urandom),
                  $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            reset = $urandom_range(0, 49) != 0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mw_wb_stage.md
MW_WB_STAGE -- requirements
Module: mw_wb_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed below.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-low; sampled only on posedge clk.
REQ-004 m_valid  in  1  M-stage slot holds a real instruction.
REQ-005 m_pc  in  32  PC of M-stage instruction.
REQ-006 m_reg_we  in  1  instruction writes a GPR.
REQ-007 m_reg_addr  in  5  destination GPR index.
REQ-008 m_wb_sel  in  2  writeback source: 00 ALU result, 01 memory, 10 PC+8, 11 reserved (treated as 00).
REQ-009 m_alu_result  in  32  ALU result (also the memory address).
REQ-010 m_mem_rdata  in  32  raw aligned data word from data memory.
REQ-011 m_load_type  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, others as lw.
REQ-012 stall  in  1  hold W-stage contents.
REQ-013 flush  in  1  load a bubble into W stage.
REQ-014 w_pc  out  32  PC of W-stage instruction, to GRF trace.
REQ-015 w_we  out  1  GRF write enable.
REQ-016 w_addr  out  5  GRF write index.
REQ-017 w_data  out  32  GRF write data.
REQ-018 w_valid  out  1  W-stage slot holds a real instruction.
REQ-019 retire_cnt  out  32  count of retired instructions.

Function
REQ-020 At posedge clk with reset high: flush=1 SHALL load a bubble (valid=0, reg_we=0, other fields 0); else stall=1 SHALL hold all W registers; else all m_* inputs SHALL be captured.
REQ-021 flush SHALL take priority over stall when both are asserted.
REQ-022 Latency: an M-stage instruction SHALL appear on w_* exactly one cycle after capture.
REQ-023 w_we SHALL be 1 only when registered valid=1, reg_we=1 and reg_addr!=0; w_addr SHALL be the registered reg_addr regardless.
REQ-024 w_data SHALL be combinational from registered fields: ALU -> alu_result; PC+8 -> pc+32'd8 (mod 2^32); memory -> load-extracted value.
REQ-025 Load extraction: byte lane = alu_result[1:0], byte k = rdata[8k+7:8k]; half lane = alu_result[1], half h = rdata[16h+15:16h]; lb/lh sign-extend, lbu/lhu zero-extend; alu_result[0] ignored for halves.
REQ-026 w_pc SHALL equal the registered pc; 0 while a bubble occupies the stage.
REQ-027 retire_cnt SHALL increment by 1 on each posedge where reset is high, stall=0 and registered valid=1 (the instruction leaving W), wrapping 0xFFFFFFFF -> 0.
REQ-028 retire_cnt SHALL NOT increment while stall=1, even if valid=1.
REQ-029 The block SHALL NOT contain combinational paths from stall/flush to any output.

Reset
REQ-030 reset=0 at posedge SHALL clear all W registers and retire_cnt to 0, overriding stall and flush.
REQ-031 After reset, w_valid=0, w_we=0, w_addr=0, w_pc=0, w_data=0, retire_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard the W-stage instruction without counting it.

Configuration
REQ-033 Macro MW_SUBWORD_LOAD_EN defined: REQ-025 extraction SHALL be implemented for all load types.
REQ-034 Macro MW_SUBWORD_LOAD_EN undefined: memory source SHALL always return rdata unmodified (lw behaviour) for every m_load_type; all other behaviour unchanged.

Verification
REQ-035 Reset low 2 cycles, then high -> all outputs 0 on first cycle after release.
REQ-036 Capture valid, reg_we=1, addr=5, wb_sel=00, alu=0x1234 -> next cycle w_we=1, w_addr=5, w_data=0x00001234; addr=0 variant -> w_we=0.
REQ-037 wb_sel=01, rdata=0x80FF7F01, alu low bits 3, lb -> w_data=0xFFFFFF80; lbu -> 0x00000080; lh with alu[1]=0 -> 0x00007F01; lhu with alu[1]=1 -> 0x000080FF; macro undefined -> 0x80FF7F01 for all.
REQ-038 wb_sel=10, pc=0x00003000 -> w_data=0x00003008; pc=0xFFFFFFFC -> w_data=0x00000004.
REQ-039 stall=1 for 3 cycles with new m_* inputs -> w_* unchanged, retire_cnt unchanged; stall+flush together -> bubble next cycle.
REQ-040 Force retire_cnt to 0xFFFFFFFF via 2^32-1 retirements (or backdoor) then retire one more -> retire_cnt=0.
